stream_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready byte stream between NUM_REQ upstream stream sources. Grants are held for a burst of up to MAX_BURST beats, and the output is a registered stage with full backpressure. The block sits between multiple stream producers and a single consumer port with the same valid/ready/data signalling as the sample stream module.

---
 rtl/stream_arbiter.sv | 179 +++++++++++++++++
 tb/tb_stream_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter sharing one registered valid/ready byte stream among NUM_REQ sources.
// Latency: a request seen in IDLE in cycle N is granted in N+1 and its first beat is on the output in N+2.
// Backpressure: the granted requester's ready is (!stream_out_valid || stream_out_ready); other readies stay low.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stream_in_valid     [NUM_REQ]            per-requester valid
//   stream_in_ready     [NUM_REQ]            per-requester ready, at most one bit high
//   stream_in_data      [NUM_REQ*DATA_WIDTH] requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   stream_out_valid    registered output valid
//   stream_out_ready    downstream ready
//   stream_out_data     [DATA_WIDTH] registered output beat
//   stream_out_src      [SRC_W] requester index of the current output beat
//   grant_active        high while a grant is held
//   stats_clear         synchronous clear of the beat counters        (STREAM_ARB_STATS_EN only)
//   grant_count         [NUM_REQ*CNT_WIDTH] saturating per-requester beat counters (STREAM_ARB_STATS_EN only)
//
// Optional feature macro: STREAM_ARB_STATS_EN adds stats_clear / grant_count. Arbitration is identical either way.

module stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            stream_in_valid,
  output logic [NUM_REQ-1:0]            stream_in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] stream_in_data,
  output logic                          stream_out_valid,
  input  logic                          stream_out_ready,
  output logic [DATA_WIDTH-1:0]         stream_out_data,
  output logic [SRC_W-1:0]              stream_out_src,
`ifdef STREAM_ARB_STATS_EN
  output logic                          grant_active,
  input  logic                          stats_clear,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_count
`else
  output logic                          grant_active
`endif
);

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 256 ||
      DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("stream_arbiter: parameter out of legal range");
  end

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] grant_idx, grant_idx_nxt;
  logic [SRC_W-1:0] last_grant, last_grant_nxt;
  logic [7:0]       beat_cnt, beat_cnt_nxt;

  logic             pick_vld;
  logic [SRC_W-1:0] pick_idx;
  logic             slot_free;
  logic             cur_valid;
  logic             xfer;

  // Unpack the data bus so the granted slice is a plain array index.
  logic [DATA_WIDTH-1:0] in_dat [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign in_dat[i] = stream_in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first valid requester starting at last_grant+1, wrapping.
  // Candidates are visited in priority order; the first hit is kept.
  always_comb begin
    int               t;
    logic [SRC_W-1:0] cand;
    t        = 0;
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      t = int'(last_grant) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      cand = SRC_W'(t);
      if (!pick_vld && stream_in_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // The output register can take a beat when empty or being drained this cycle.
  assign slot_free = !stream_out_valid || stream_out_ready;
  assign cur_valid = stream_in_valid[grant_idx];
  assign xfer      = (state == GRANT) && cur_valid && slot_free;

  assign grant_active = (state == GRANT);

  always_comb begin
    state_nxt       = state;
    grant_idx_nxt   = grant_idx;
    last_grant_nxt  = last_grant;
    beat_cnt_nxt    = beat_cnt;
    stream_in_ready = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_idx_nxt = pick_idx;
          beat_cnt_nxt  = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        stream_in_ready[grant_idx] = slot_free;
        if (!cur_valid) begin
          // Requester released its grant; no beat is taken this cycle.
          state_nxt      = IDLE;
          last_grant_nxt = grant_idx;
        end else if (xfer) begin
          if (beat_cnt == BURST_LAST) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_idx;
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_idx  <= grant_idx_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Output stage: load on transfer, hold under backpressure, empty when drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      stream_out_valid <= 1'b0;
      stream_out_data  <= '0;
      stream_out_src   <= '0;
    end else if (xfer) begin
      stream_out_valid <= 1'b1;
      stream_out_data  <= in_dat[grant_idx];
      stream_out_src   <= grant_idx;
    end else if (stream_out_ready) begin
      stream_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_ARB_STATS_EN
  // Per-requester accepted-beat counters; clear wins over a same-cycle increment.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset || stats_clear) begin
        cnt <= '0;
      end else if (xfer && (grant_idx == SRC_W'(i)) && (cnt != '1)) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
    assign grant_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: queued source stimulus, scoreboard of expected output beats,
// plus direct checks on reset values, stall behaviour, grant release and statistics.
module tb_stream_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] in_valid;
  logic [NREQ-1:0] in_ready;
  logic [NREQ*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            grant_active;
`ifdef STREAM_ARB_STATS_EN
  logic            stats_clear;
  logic [NREQ*CW-1:0] grant_count;
`endif

  typedef struct {
    logic [7:0] dat;
    logic [1:0] src;
    int         cyc;   // expected consume cycle, -1 when not pinned
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] src_q [NREQ][$];
  logic [7:0] src_dat [NREQ];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_bad = 0;

  assign in_data = {src_dat[3], src_dat[2], src_dat[1], src_dat[0]};

  stream_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stream_in_valid(in_valid),
    .stream_in_ready(in_ready),
    .stream_in_data(in_data),
    .stream_out_valid(out_valid),
    .stream_out_ready(out_ready),
    .stream_out_data(out_data),
    .stream_out_src(out_src),
`ifdef STREAM_ARB_STATS_EN
    .grant_active(grant_active),
    .stats_clear(stats_clear),
    .grant_count(grant_count)
`else
    .grant_active(grant_active)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic stim(input int r, input logic [7:0] d);
    src_q[r].push_back(d);
  endtask

  task automatic expect_beat(input logic [7:0] d, input int s, input int ecyc);
    exp_t e;
    e.dat = d;
    e.src = 2'(s);
    e.cyc = ecyc;
    sb_q.push_back(e);
  endtask

  // Source driver: a beat leaves its queue after a handshake seen at the negedge.
  initial begin : src_driver
    logic [NREQ-1:0] fire;
    in_valid = '0;
    for (int r = 0; r < NREQ; r++) src_dat[r] = 8'h00;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (fire[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        if (src_q[r].size() > 0) begin
          in_valid[r] = 1'b1;
          src_dat[r]  = src_q[r][0];
        end else begin
          in_valid[r] = 1'b0;
        end
      end
    end
  end

  // Output monitor: every consumed beat must match the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_extra_beat", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_data", 32'(out_data), 32'(e.dat));
          check_eq("sb_src", 32'(out_src), 32'(e.src));
          if (e.cyc >= 0) check_eq("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d sb_left=%0d", cyc, sb_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    for (int r = 0; r < NREQ; r++) src_q[r].delete();
    sb_q.delete();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sb_q.size() != 0 && n < budget);
    #1;
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < budget);
    check_eq(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin : main
    int t0;
    int n;
    reset     = 1'b1;
    out_ready = 1'b1;
`ifdef STREAM_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_src", 32'(out_src), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_grant_active", 32'(grant_active), 32'd0);
`ifdef STREAM_ARB_STATS_EN
    check_eq("rst_grant_count", 32'(grant_count), 32'd0);
`endif

    // Single requester, 10 beats: gaps after beats 3 and 7, first output 2 cycles after valid.
    do_reset();
    t0 = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      stim(0, 8'(k));
      expect_beat(8'(k), 0, t0 + 2 + k + k / MB);
    end
    drain("t1_drain", 100);

    // All four requesters busy: bursts of 4 in order 0,1,2,3,0,1,2,3 with one idle cycle between.
    do_reset();
    t0 = cyc + 1;
    for (int r = 0; r < NREQ; r++)
      for (int j = 0; j < 8; j++) stim(r, 8'(r));
    for (int k = 0; k < 32; k++)
      expect_beat(8'((k / 4) % 4), (k / 4) % 4, t0 + 2 + k + k / 4);
    drain("t2_drain", 200);

    // Backpressure for 5 cycles mid-burst: second beat held, no source ready.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      stim(1, 8'(8'h10 + k));
      expect_beat(8'(8'h10 + k), 1, -1);
    end
    wait_out_valid("t3_first_valid", 20);
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t3_hold_data", 32'(out_data), 32'h11);
      check_eq("t3_hold_src", 32'(out_src), 32'd1);
      check_eq("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    drain("t3_drain", 100);

    // Early release by requester 2 after 2 beats; requester 3 is next.
    do_reset();
    stim(2, 8'h20); stim(2, 8'h21);
    expect_beat(8'h20, 2, -1); expect_beat(8'h21, 2, -1);
    @(negedge clk); #1;
    stim(3, 8'h30); stim(3, 8'h31); stim(0, 8'h40); stim(0, 8'h41);
    expect_beat(8'h30, 3, -1); expect_beat(8'h31, 3, -1);
    expect_beat(8'h40, 0, -1); expect_beat(8'h41, 0, -1);
    repeat (3) @(negedge clk);
    check_eq("t4a_grant_during_release", 32'(grant_active), 32'd1);
    @(negedge clk);
    check_eq("t4a_grant_after_release", 32'(grant_active), 32'd0);
    check_eq("t4a_ready_after_release", 32'(in_ready), 32'd0);
    drain("t4a_drain", 100);

    // Early release with requester 3 idle: search wraps to 0, then 1.
    do_reset();
    stim(2, 8'h22); stim(2, 8'h23);
    expect_beat(8'h22, 2, -1); expect_beat(8'h23, 2, -1);
    @(negedge clk); #1;
    stim(0, 8'h50); stim(0, 8'h51); stim(1, 8'h60); stim(1, 8'h61);
    expect_beat(8'h50, 0, -1); expect_beat(8'h51, 0, -1);
    expect_beat(8'h60, 1, -1); expect_beat(8'h61, 1, -1);
    drain("t4b_drain", 100);

    // Reset while a beat is held: outputs return to reset values, requester 0 wins next.
    do_reset();
    for (int k = 0; k < 6; k++) stim(2, 8'(8'hA0 + k));
    expect_beat(8'hA0, 2, -1);
    wait_out_valid("t5_first_valid", 20);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    check_eq("t5_held_valid", 32'(out_valid), 32'd1);
    check_eq("t5_held_data", 32'(out_data), 32'hA1);
    #1;
    check_eq("t5_pre_reset_sb", sb_q.size(), 0);
    for (int r = 0; r < NREQ; r++) src_q[r].delete();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_out_data", 32'(out_data), 32'd0);
    check_eq("t5_rst_out_src", 32'(out_src), 32'd0);
    check_eq("t5_rst_grant_active", 32'(grant_active), 32'd0);
    check_eq("t5_rst_in_ready", 32'(in_ready), 32'd0);
    #1;
    stim(3, 8'hB0); stim(0, 8'hC0);
    expect_beat(8'hC0, 0, -1); expect_beat(8'hB0, 3, -1);
    drain("t5_drain", 100);

`ifdef STREAM_ARB_STATS_EN
    // 20 beats from requester 1 saturate its 4-bit counter at 15.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      stim(1, 8'(k));
      expect_beat(8'(k), 1, -1);
    end
    drain("t6_drain", 200);
    check_eq("t6_cnt1_sat", 32'(grant_count[1*CW +: CW]), 32'd15);
    check_eq("t6_cnt0_zero", 32'(grant_count[0*CW +: CW]), 32'd0);
    // Clear coinciding with a transfer wins; the remaining 2 beats count afterwards.
    for (int k = 0; k < 3; k++) begin
      stim(1, 8'(8'h70 + k));
      expect_beat(8'(8'h70 + k), 1, -1);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_valid[1] && in_ready[1]) && n < 20);
    check_eq("t6_xfer_seen", 32'(in_valid[1] && in_ready[1]), 32'd1);
    #1; stats_clear = 1'b1;
    @(posedge clk); #1; stats_clear = 1'b0;
    @(negedge clk);
    check_eq("t6_cnt1_cleared", 32'(grant_count[1*CW +: CW]), 32'd0);
    drain("t6_clear_drain", 100);
    check_eq("t6_cnt1_after", 32'(grant_count[1*CW +: CW]), 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
